// File: rtl/inv_aes_pkg.sv
// Shared types and GF(2^8) helpers for the iterative AES inverse-cipher datapath.
// Latency: n/a (package). Backpressure: n/a.
// Contents: FSM state enum, round-count constants, 128-bit block type, inverse S-box math.
package inv_aes_pkg;

    localparam int NR_128 = 10;
    localparam int NR_192 = 12;
    localparam int NR_256 = 14;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } fsm_state_t;

    // Byte 0 of the AES state sits in bits [127:120]; bytes fill columns first.
    typedef logic [127:0] block_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254; maps 0 to 0 as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] e;
        r = 8'h01;
        e = 8'hfe;
        for (int i = 7; i >= 0; i--) begin
            r = gf_mul(r, r);
            if (e[i]) r = gf_mul(r, x);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int unsigned n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    // Undo the affine transform first, then invert in the field.
    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [7:0] a;
        a = rotl8(b, 1) ^ rotl8(b, 3) ^ rotl8(b, 6) ^ 8'h05;
        return gf_inv(a);
    endfunction

endpackage

// File: rtl/inv_round_comb.sv
// One AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns unless last.
// Latency: purely combinational. Backpressure: none (no handshake).
// Ports: state/key in, last skips InvMixColumns, next_state out.
module inv_round_comb
    import inv_aes_pkg::*;
(
    input  block_t state,
    input  block_t key,
    input  logic   last,
    output block_t next_state
);

    logic [7:0] in_b  [16];
    logic [7:0] sr_b  [16];
    logic [7:0] ark_b [16];
    logic [7:0] out_b [16];

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            in_b[i] = state[127-8*i -: 8];
        end
        // Row r rotates right by r columns.
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr_b[4*c+r] = in_b[4*((c + 4 - r) % 4) + r];
            end
        end
        for (int i = 0; i < 16; i++) begin
            ark_b[i] = inv_sbox(sr_b[i]) ^ key[127-8*i -: 8];
        end
        for (int c = 0; c < 4; c++) begin
            if (last) begin
                for (int r = 0; r < 4; r++) out_b[4*c+r] = ark_b[4*c+r];
            end else begin
                out_b[4*c+0] = gf_mul(ark_b[4*c+0], 8'h0e) ^ gf_mul(ark_b[4*c+1], 8'h0b)
                             ^ gf_mul(ark_b[4*c+2], 8'h0d) ^ gf_mul(ark_b[4*c+3], 8'h09);
                out_b[4*c+1] = gf_mul(ark_b[4*c+0], 8'h09) ^ gf_mul(ark_b[4*c+1], 8'h0e)
                             ^ gf_mul(ark_b[4*c+2], 8'h0b) ^ gf_mul(ark_b[4*c+3], 8'h0d);
                out_b[4*c+2] = gf_mul(ark_b[4*c+0], 8'h0d) ^ gf_mul(ark_b[4*c+1], 8'h09)
                             ^ gf_mul(ark_b[4*c+2], 8'h0e) ^ gf_mul(ark_b[4*c+3], 8'h0b);
                out_b[4*c+3] = gf_mul(ark_b[4*c+0], 8'h0b) ^ gf_mul(ark_b[4*c+1], 8'h0d)
                             ^ gf_mul(ark_b[4*c+2], 8'h09) ^ gf_mul(ark_b[4*c+3], 8'h0e);
            end
        end
        next_state = '0;
        for (int i = 0; i < 16; i++) begin
            next_state[127-8*i -: 8] = out_b[i];
        end
    end

endmodule

// File: rtl/inv_round_iter.sv
// Iterative AES inverse cipher, one round per cycle through a single shared round block.
// Latency: NR cycles from acceptance edge to first out_valid; next block can load on the output edge.
// Backpressure: result held in DONE while out_ready=0; in_ready follows out_ready there.
// Ports: clk, rst_n (sync, active-low); in_valid/in_ready/in_data; rk_idx out, rk_data in (same cycle);
//        out_valid/out_ready/out_data; busy while rounds are running.
module inv_round_iter
    import inv_aes_pkg::*;
#(
    parameter int NR = NR_128
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    generate
        if (NR != NR_128 && NR != NR_192 && NR != NR_256) begin : g_bad_nr
            $error("inv_round_iter: NR must be 10, 12 or 14");
        end
    endgenerate

    localparam logic [3:0] NR_IDX   = 4'(NR);
    localparam logic [3:0] LAST_CNT = 4'(NR - 1);

    fsm_state_t fsm;
    logic [3:0] cnt;
    block_t     state_reg;
    block_t     round_out;
    logic       out_valid_q;
    logic       busy_q;

    inv_round_comb u_round (
        .state      (state_reg),
        .key        (rk_data),
        .last       (cnt == 4'd0),
        .next_state (round_out)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm         <= ST_IDLE;
            cnt         <= 4'd0;
            state_reg   <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (fsm)
                ST_IDLE: begin
                    if (in_valid) begin
                        // rk_idx is NR here, so rk_data is the final encryption key.
                        state_reg <= in_data ^ rk_data;
                        cnt       <= LAST_CNT;
                        fsm       <= ST_ROUND;
                        busy_q    <= 1'b1;
                    end
                end
                ST_ROUND: begin
                    state_reg <= round_out;
                    if (cnt == 4'd0) begin
                        fsm         <= ST_DONE;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (in_valid) begin
                            // Output leaves and the next block loads on the same edge.
                            state_reg <= in_data ^ rk_data;
                            cnt       <= LAST_CNT;
                            fsm       <= ST_ROUND;
                            busy_q    <= 1'b1;
                        end else begin
                            fsm <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    fsm         <= ST_IDLE;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = (fsm == ST_IDLE) || ((fsm == ST_DONE) && out_ready);
    assign rk_idx    = (fsm == ST_ROUND) ? cnt : NR_IDX;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_data  = state_reg;

endmodule

// File: tb/tb_inv_round_iter.sv
module tb_inv_round_iter;

    logic clk;
    logic rst_n;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic         in_valid  [3];
    logic [127:0] in_data   [3];
    logic         out_ready [3];
    wire          in_ready  [3];
    wire          out_valid [3];
    wire          busy      [3];
    wire  [127:0] out_data  [3];
    wire  [3:0]   rk_idx    [3];
    wire  [127:0] rk_data   [3];
    logic [127:0] rkeys     [3][15];

    // Instance g runs NR = 10 + 2g.
    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : g_dut
            inv_round_iter #(.NR(10 + 2*g)) u_dut (
                .clk       (clk),
                .rst_n     (rst_n),
                .in_valid  (in_valid[g]),
                .in_ready  (in_ready[g]),
                .in_data   (in_data[g]),
                .rk_idx    (rk_idx[g]),
                .rk_data   (rk_data[g]),
                .out_valid (out_valid[g]),
                .out_ready (out_ready[g]),
                .out_data  (out_data[g]),
                .busy      (busy[g])
            );
            assign rk_data[g] = rkeys[g][rk_idx[g]];
        end
    endgenerate

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int           g;
        logic [127:0] pt;
        int           acc;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        int           g;
        logic [255:0] key;
        logic [127:0] ct;
        logic [127:0] pt;
    } vec_t;
    vec_t vecs[4];

    logic [7:0] sbox_t [256];
    logic       prev_v    [3];
    int         last_rise [3];
    int         prev_rise [3];
    int         xfers     [3];

    task automatic chk_blk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int nr_of(input int gi);
        return 10 + 2*gi;
    endfunction

    function automatic logic [7:0] t_xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] t_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = t_xt(aa);
        end
        return p;
    endfunction

    function automatic logic [7:0] t_rotl(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    // Forward S-box by brute-force x^254 followed by the forward affine map.
    task automatic build_sbox();
        logic [7:0] r;
        logic [7:0] b;
        for (int x = 0; x < 256; x++) begin
            b = 8'(x);
            r = 8'h01;
            for (int k = 0; k < 254; k++) r = t_mul(r, b);
            sbox_t[x] = r ^ t_rotl(r, 1) ^ t_rotl(r, 2) ^ t_rotl(r, 3) ^ t_rotl(r, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
    endfunction

    // FIPS-197 key expansion; key is left-aligned in 256 bits.
    task automatic expand(input int gi, input logic [255:0] key);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        int nk;
        int nr;
        nk = 4 + 2*gi;
        nr = nr_of(gi);
        rc = 8'h01;
        for (int i = 0; i < 60; i++) w[i] = 32'h0;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = subw({t[23:0], t[31:24]});
                t[31:24] = t[31:24] ^ rc;
                rc = t_xt(rc);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int k = 0; k <= nr; k++) rkeys[gi][k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
    endtask

    // Forward cipher used to make fresh ciphertexts for random plaintexts.
    function automatic logic [127:0] enc(input int gi, input logic [127:0] pt);
        logic [7:0] s [16];
        logic [7:0] u [16];
        logic [7:0] a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rkeys[gi][0][127-8*i -: 8];
        for (int r = 1; r <= nr_of(gi); r++) begin
            for (int i = 0; i < 16; i++) u[i] = sbox_t[s[i]];
            for (int c = 0; c < 4; c++)
                for (int w = 0; w < 4; w++) s[4*c+w] = u[4*((c+w)%4)+w];
            if (r != nr_of(gi)) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = t_xt(a0) ^ t_xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ t_xt(a1) ^ t_xt(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ t_xt(a2) ^ t_xt(a3) ^ a3;
                    s[4*c+3] = t_xt(a0) ^ a0 ^ a1 ^ a2 ^ t_xt(a3);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rkeys[gi][r][127-8*i -: 8];
        end
        res = '0;
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    task automatic push(input int gi, input logic [127:0] pt, input int acc);
        exp_t e;
        e.g   = gi;
        e.pt  = pt;
        e.acc = acc;
        sbq.push_back(e);
    endtask

    // Called just after a rising edge; returns just after a rising edge with in_valid low.
    task automatic offer(input int gi, input logic [127:0] ct, input logic [127:0] pt);
        bit ok;
        ok = 1'b0;
        in_valid[gi] = 1'b1;
        in_data[gi]  = ct;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (in_ready[gi]) begin
                push(gi, pt, cyc + 1);
                ok = 1'b1;
                break;
            end
        end
        chk_int("accept_timeout", int'(ok), 1);
        @(posedge clk);
        #1;
        in_valid[gi] = 1'b0;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (sbq.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        chk_int("drain_timeout", int'(done), 1);
        @(posedge clk);
        #1;
    endtask

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // Output monitor: latency on every out_valid rise, data on every transfer.
    initial begin
        for (int i = 0; i < 3; i++) begin
            prev_v[i] = 1'b0; last_rise[i] = 0; prev_rise[i] = 0; xfers[i] = 0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (out_valid[i] && !prev_v[i]) begin
                    prev_rise[i] = last_rise[i];
                    last_rise[i] = cyc;
                    if (sbq.size() == 0 || sbq[0].g != i) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_out_valid: dut %0d got 1 expected 0", i);
                    end else begin
                        chk_int("latency", cyc, sbq[0].acc + nr_of(i));
                    end
                end
                if (rst_n && out_valid[i] && out_ready[i] && sbq.size() > 0 && sbq[0].g == i) begin
                    chk_blk("out_data", out_data[i], sbq[0].pt);
                    void'(sbq.pop_front());
                    xfers[i]++;
                end
                prev_v[i] = out_valid[i];
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    logic [127:0] pa, pb, ca, cb, held;
    bit           ok, seen;
    int           x0;

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid[i] = 1'b0; in_data[i] = '0; out_ready[i] = 1'b1;
        end
        vecs[0] = '{0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
                    128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h00112233445566778899aabbccddeeff};
        vecs[1] = '{1, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0},
                    128'hdda97ca4864cdfe06eaf70a0ec0d7191, 128'h00112233445566778899aabbccddeeff};
        vecs[2] = '{2, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                    128'h8ea2b7ca516745bfeafc49904b496089, 128'h00112233445566778899aabbccddeeff};
        vecs[3] = '{0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
                    128'h3925841d02dc09fbdc118597196a0b32, 128'h3243f6a8885a308d313198a2e0370734};
        build_sbox();
        for (int i = 0; i < 3; i++) expand(i, vecs[i].key);

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk_int("rst_in_ready", int'(in_ready[i]), 1);
            chk_int("rst_out_valid", int'(out_valid[i]), 0);
            chk_int("rst_busy", int'(busy[i]), 0);
            chk_int("rst_rk_idx", int'(rk_idx[i]), nr_of(i));
            chk_blk("rst_out_data", out_data[i], 128'h0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Known-answer vectors
        for (int v = 0; v < 4; v++) begin
            expand(vecs[v].g, vecs[v].key);
            offer(vecs[v].g, vecs[v].ct, vecs[v].pt);
            drain();
        end
        // Random plaintexts through the bench forward cipher
        for (int i = 0; i < 3; i++) begin
            expand(i, vecs[i].key);
            for (int r = 0; r < 2; r++) begin
                pa = {$urandom, $urandom, $urandom, $urandom};
                offer(i, enc(i, pa), pa);
                drain();
            end
        end

        // rk_idx trace on NR=10; in_valid held high with junk during ROUND
        in_valid[0] = 1'b1;
        in_data[0]  = vecs[0].ct;
        @(negedge clk);
        chk_int("trace_in_ready", int'(in_ready[0]), 1);
        chk_int("trace_rk_idx_accept", int'(rk_idx[0]), 10);
        push(0, vecs[0].pt, cyc + 1);
        @(posedge clk);
        #1;
        in_data[0] = 128'hdeadbeef_00000000_cafef00d_12345678;
        for (int k = 9; k >= 0; k--) begin
            @(negedge clk);
            chk_int("trace_rk_idx", int'(rk_idx[0]), k);
            chk_int("trace_busy", int'(busy[0]), 1);
            chk_int("trace_in_ready_round", int'(in_ready[0]), 0);
            chk_int("trace_out_valid_round", int'(out_valid[0]), 0);
            if (k == 0) begin
                @(posedge clk);
                #1;
                in_valid[0] = 1'b0;
            end
        end
        @(negedge clk);
        chk_int("trace_done_valid", int'(out_valid[0]), 1);
        chk_int("trace_done_rk_idx", int'(rk_idx[0]), 10);
        chk_int("trace_done_busy", int'(busy[0]), 0);
        drain();

        // Backpressure: 5 cycles of out_ready=0 in DONE
        out_ready[0] = 1'b0;
        pa = {$urandom, $urandom, $urandom, $urandom};
        offer(0, enc(0, pa), pa);
        ok = 1'b0;
        for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            if (out_valid[0]) begin
                ok = 1'b1;
                break;
            end
        end
        chk_int("bp_valid_timeout", int'(ok), 1);
        held = out_data[0];
        x0   = xfers[0];
        for (int i = 0; i < 5; i++) begin
            chk_int("bp_out_valid", int'(out_valid[0]), 1);
            chk_blk("bp_out_data", out_data[0], pa);
            chk_blk("bp_stable", out_data[0], held);
            chk_int("bp_in_ready", int'(in_ready[0]), 0);
            if (i < 4) @(negedge clk);
        end
        @(posedge clk);
        #1;
        out_ready[0] = 1'b1;
        @(negedge clk);
        chk_int("bp_in_ready_follows", int'(in_ready[0]), 1);
        @(negedge clk);
        chk_int("bp_after_valid", int'(out_valid[0]), 0);
        chk_int("bp_single_xfer", xfers[0], x0 + 1);
        @(posedge clk);
        #1;

        // Back-to-back with in_valid and out_ready held high
        pa = {$urandom, $urandom, $urandom, $urandom};
        pb = {$urandom, $urandom, $urandom, $urandom};
        ca = enc(0, pa);
        cb = enc(0, pb);
        in_valid[0] = 1'b1;
        in_data[0]  = ca;
        @(negedge clk);
        chk_int("b2b_first_ready", int'(in_ready[0]), 1);
        push(0, pa, cyc + 1);
        @(posedge clk);
        #1;
        in_data[0] = cb;
        ok = 1'b0;
        for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            if (in_ready[0]) begin
                ok = 1'b1;
                break;
            end
        end
        chk_int("b2b_accept", int'(ok), 1);
        chk_int("b2b_same_cycle_out", int'(out_valid[0]), 1);
        push(0, pb, cyc + 1);
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        drain();
        chk_int("b2b_spacing", last_rise[0] - prev_rise[0], 11);

        // Reset in the 4th ROUND cycle discards the block
        in_valid[0] = 1'b1;
        in_data[0]  = ca;
        @(negedge clk);
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk_int("rst_mid_busy_before", int'(busy[0]), 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk_int("rst_mid_in_ready", int'(in_ready[0]), 1);
        chk_int("rst_mid_busy", int'(busy[0]), 0);
        chk_int("rst_mid_out_valid", int'(out_valid[0]), 0);
        chk_int("rst_mid_rk_idx", int'(rk_idx[0]), 10);
        chk_blk("rst_mid_out_data", out_data[0], 128'h0);
        seen = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (out_valid[0]) seen = 1'b1;
        end
        chk_int("rst_mid_no_out", int'(seen), 0);
        @(posedge clk);
        #1;
        offer(0, cb, pb);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inv_round_iter.md
INV_ROUND_ITER -- requirements
Module: inv_round_iter

Interface
REQ-001 The module SHALL provide parameter NR, default 10, meaning the number of AES rounds; legal values are 10, 12 and 14 (AES-128/192/256).
REQ-002 The module SHALL provide the following ports, one per line: name, direction, width, meaning.
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  ciphertext block offered.
- in_ready  output  1  block accepted when in_valid && in_ready.
- in_data  input  128  ciphertext block, same byte order as the existing round datapath.
- rk_idx  output  4  index of the round key required this cycle.
- rk_data  input  128  round key rk[rk_idx], supplied combinationally in the same cycle.
- out_valid  output  1  plaintext block available.
- out_ready  input  1  consumer accepts when out_valid && out_ready.
- out_data  output  128  plaintext block.
- busy  output  1  high in ROUND state.

Function
REQ-003 The FSM SHALL have three states: IDLE, ROUND and DONE.
REQ-004 In IDLE, in_ready SHALL be 1 and rk_idx SHALL be NR; on acceptance, state_reg <= in_data ^ rk_data, cnt <= NR-1, and the FSM SHALL go to ROUND.
REQ-005 In ROUND, rk_idx SHALL equal cnt, and each cycle state_reg SHALL be updated with one inverse round in this order: InvShiftRows, InvSubBytes, AddRoundKey(rk_data), then InvMixColumns.
REQ-006 InvMixColumns SHALL be skipped when cnt==0, which is the last round.
REQ-007 In ROUND, cnt SHALL decrement by 1 per cycle; when the round with cnt==0 completes, the FSM SHALL go to DONE.
REQ-008 Latency SHALL be exactly NR cycles from the acceptance edge to the first cycle with out_valid=1.
REQ-009 In DONE, out_valid SHALL be 1 and out_data SHALL equal state_reg, held stable while out_ready=0 (no data loss under backpressure).
REQ-010 In DONE, in_ready SHALL equal out_ready and rk_idx SHALL be NR.
REQ-011 DONE with out_ready=1 and in_valid=1 SHALL perform the output transfer and a new acceptance in the same cycle (back-to-back, next state ROUND).
REQ-012 DONE with out_ready=1 and in_valid=0 SHALL return to IDLE.
REQ-013 In ROUND, in_ready SHALL be 0 and out_valid SHALL be 0; in_valid SHALL be ignored.
REQ-014 All XOR and S-box operations SHALL be 128-bit bytewise, with no carries and no width extension; cnt SHALL be 4 bits and SHALL never wrap below 0.
REQ-015 rk_idx SHALL be a pure function of the FSM state and cnt (registered-state decode), with no combinational path from in_valid or out_ready.

Reset
REQ-016 When rst_n=0 at a rising edge, the FSM SHALL go to IDLE, with cnt=0, state_reg=0, out_valid=0, busy=0 and in_ready=1 in the following cycle.
REQ-017 Reset asserted during ROUND or DONE SHALL discard the block in flight without producing out_valid.
REQ-018 No output SHALL depend on rst_n combinationally.

Structure
REQ-019 Package inv_aes_pkg SHALL hold the FSM state enum, the NR_128/NR_192/NR_256 constants, the 128-bit block typedef and the S-box/GF(2^8) helper functions.
REQ-020 One combinational sub-module, inv_round_comb (inputs: state, key, last; output: next state), SHALL implement REQ-005 and REQ-006, and SHALL be instantiated once and reused every cycle.
REQ-021 An elaboration-time check SHALL reject NR values other than 10, 12 and 14.

Verification
REQ-022 NR=10, rk from the bench key model for key 000102030405060708090a0b0c0d0e0f, in_data 69c4e0d86a7b0430d8cdb78070b4c55a -> out_data 00112233445566778899aabbccddeeff, out_valid exactly 10 cycles after acceptance.
REQ-023 NR=12, key 000102...1617, in_data dda97ca4864cdfe06eaf70a0ec0d7191 -> 00112233445566778899aabbccddeeff after 12 cycles; NR=14, key 000102...1e1f, in_data 8ea2b7ca516745bfeafc49904b496089 -> same plaintext after 14 cycles.
REQ-024 Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid and out_data stable, in_ready=0 throughout, and a single transfer when out_ready rises.
REQ-025 Back-to-back: two blocks with in_valid and out_ready held at 1 -> second block accepted in the same cycle as the first output; outputs spaced NR+1 cycles apart.
REQ-026 Reset mid-operation: deassert rst_n at cycle 4 of ROUND -> IDLE next cycle, no out_valid; a subsequent block decrypts correctly.
REQ-027 rk_idx trace: for NR=10, the sequence SHALL be 10 at acceptance, then 9, 8, ..., 0 on consecutive ROUND cycles.
